// File: rtl/double_to_float.sv
// double_to_float: IEEE-754 binary64 to binary32 converter, round-to-nearest-even,
// strobe/ack handshake on both sides, one shift per cycle on the subnormal path.
module double_to_float (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);
    typedef enum logic [2:0] {get_a, unpack, align, round, pack, put_z} state_t;
    state_t state, state_n;
    logic [63:0] a, a_n;
    logic [11:0] fexp, fexp_n, exp_t;
    logic [24:0] sig, sig_n;
    logic g, g_n, r, r_n, st, st_n, spec, spec_n, sub, sub_n, ack_n, zstb_n;
    logic [4:0] k, k_n;
    logic [31:0] res, res_n, z_n;
    logic [10:0] e;
    logic [51:0] m;
    assign e = a[62:52];
    assign m = a[51:0];
    assign exp_t = fexp + {11'b0, sig[24]};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= get_a;
            a <= '0;
            fexp <= '0;
            sig <= '0;
            g <= 1'b0;
            r <= 1'b0;
            st <= 1'b0;
            spec <= 1'b0;
            sub <= 1'b0;
            k <= '0;
            res <= '0;
            input_a_ack <= 1'b0;
            output_z <= '0;
            output_z_stb <= 1'b0;
        end else begin
            state <= state_n;
            a <= a_n;
            fexp <= fexp_n;
            sig <= sig_n;
            g <= g_n;
            r <= r_n;
            st <= st_n;
            spec <= spec_n;
            sub <= sub_n;
            k <= k_n;
            res <= res_n;
            input_a_ack <= ack_n;
            output_z <= z_n;
            output_z_stb <= zstb_n;
        end
    end
    always_comb begin
        state_n = state;
        a_n = a;
        fexp_n = fexp;
        sig_n = sig;
        g_n = g;
        r_n = r;
        st_n = st;
        spec_n = spec;
        sub_n = sub;
        k_n = k;
        res_n = res;
        ack_n = input_a_ack;
        z_n = output_z;
        zstb_n = output_z_stb;
        case (state)
            get_a: begin
                ack_n = 1'b1;
                if (input_a_ack && input_a_stb) begin
                    ack_n = 1'b0;
                    a_n = input_a;
                    state_n = unpack;
                end
            end
            unpack: begin
                fexp_n = {1'b0, e} - 12'd896;
                sig_n = {2'b01, m[51:29]};
                g_n = m[28];
                r_n = m[27];
                st_n = |m[26:0];
                k_n = 5'(11'd897 - e);
                spec_n = 1'b1;
                sub_n = 1'b0;
                state_n = pack;
                // NaN keeps only the quiet bit; infinity and overflow share the same encoding
                if (e == 11'd2047)
                    res_n = {a[63], 8'hff, |m, 22'b0};
                else if (e <= 11'd872)
                    res_n = {a[63], 31'b0};
                else if (e >= 11'd1151)
                    res_n = {a[63], 8'hff, 23'b0};
                else begin
                    spec_n = 1'b0;
                    sub_n = e <= 11'd896;
                    state_n = e <= 11'd896 ? align : round;
                end
            end
            align: begin
                sig_n = sig >> 1;
                g_n = sig[0];
                r_n = g;
                st_n = st | r;
                k_n = k - 5'd1;
                if (k == 5'd1) state_n = round;
            end
            round: begin
                if (g && (r || st || sig[0])) sig_n = sig + 25'd1;
                state_n = pack;
            end
            pack: begin
                if (!spec)
                    res_n = sub ? {a[63], 7'b0, sig[23:0]} :
                            exp_t >= 12'd255 ? {a[63], 8'hff, 23'b0} :
                            {a[63], exp_t[7:0], sig[24] ? 23'b0 : sig[22:0]};
                state_n = put_z;
            end
            put_z: begin
                zstb_n = 1'b1;
                z_n = res;
                if (output_z_stb && output_z_ack) begin
                    zstb_n = 1'b0;
                    state_n = get_a;
                end
            end
            default: state_n = get_a;
        endcase
    end
endmodule

// File: tb/tb_double_to_float.sv
// tb_double_to_float: directed vectors, handshake/reset sequences and a random
// stream checked against an exact-arithmetic rounding model.
module tb_double_to_float;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [63:0] input_a = '0;
    logic input_a_stb = 1'b0;
    logic input_a_ack;
    logic [31:0] output_z;
    logic output_z_stb;
    logic output_z_ack = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    double_to_float dut (
        .clk(clk),
        .rst(rst),
        .input_a(input_a),
        .input_a_stb(input_a_stb),
        .input_a_ack(input_a_ack),
        .output_z(output_z),
        .output_z_stb(output_z_stb),
        .output_z_ack(output_z_ack)
    );

    typedef struct {
        logic [63:0] a;
        logic [31:0] z;
        int          lat;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Round v / 2^sh to the nearest integer, ties to even.
    function automatic logic [63:0] rne(input logic [63:0] v, input int sh);
        logic [63:0] q, rem, half;
        if (sh >= 64) return 64'd0;
        q = v >> sh;
        rem = v & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        return q;
    endfunction

    // Value = M * 2^(e-1075); quantise to the binary32 grid, which is 2^(L-23)
    // for normals and 2^-149 below the normal range.
    function automatic logic [31:0] model(input logic [63:0] d);
        logic s;
        int e, lexp, q, b;
        logic [63:0] mm, rr;
        s = d[63];
        e = int'(d[62:52]);
        if (e == 2047) return d[51:0] != 0 ? {s, 8'hff, 1'b1, 22'b0} : {s, 8'hff, 23'b0};
        if (e == 0) return {s, 31'b0};
        mm = {11'b0, 1'b1, d[51:0]};
        lexp = e - 1023;
        q = lexp >= -126 ? lexp - 23 : -149;
        rr = rne(mm, q - (e - 1075));
        if (lexp < -126) return {s, rr[30:0]};
        if (rr[24]) begin
            rr = rr >> 1;
            q++;
        end
        b = q + 150;
        if (b >= 255) return {s, 8'hff, 23'b0};
        return {s, 8'(b), rr[22:0]};
    endfunction

    function automatic int lat_model(input logic [63:0] d);
        int e;
        e = int'(d[62:52]);
        if (e == 2047 || e <= 872 || e >= 1151) return 3;
        if (e >= 897) return 4;
        return 4 + 897 - e;
    endfunction

    task automatic send(input logic [63:0] d);
        int n;
        input_a = d;
        input_a_stb = 1'b1;
        n = 0;
        while (!input_a_ack && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("accept_ready", input_a_ack, 1);
        @(posedge clk);
        #1;
        input_a_stb = 1'b0;
        input_a = {$urandom, $urandom};
    endtask

    task automatic recv(output logic [31:0] z, output int lat);
        lat = 0;
        while (!output_z_stb && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("ack_stb_exclusive", input_a_ack & output_z_stb, 0);
        z = output_z;
    endtask

    task automatic release_z();
        output_z_ack = 1'b1;
        @(posedge clk);
        #1;
        output_z_ack = 1'b0;
        check("stb_drop", output_z_stb, 0);
    endtask

    task automatic conv(input string nm, input logic [63:0] d, input logic [31:0] ez, input int el);
        logic [31:0] z;
        int lat;
        send(d);
        recv(z, lat);
        check({nm, "_z"}, z, ez);
        check({nm, "_lat"}, lat, el);
        release_z();
    endtask

    initial begin
        logic [31:0] z;
        int lat;
        logic [63:0] d;
        int sel;
        vecs[0]  = '{64'h3FF0000000000000, 32'h3F800000, 4};
        vecs[1]  = '{64'hBFB999999999999A, 32'hBDCCCCCD, 4};
        vecs[2]  = '{64'h7FF0000000000001, 32'h7FC00000, 3};
        vecs[3]  = '{64'hFFF0000000000000, 32'hFF800000, 3};
        vecs[4]  = '{64'h8000000000000000, 32'h80000000, 3};
        vecs[5]  = '{64'h7E37E43C8800759C, 32'h7F800000, 3};
        vecs[6]  = '{64'h47EFFFFFF0000000, 32'h7F800000, 4};
        vecs[7]  = '{64'h3FF0000010000000, 32'h3F800000, 4};
        vecs[8]  = '{64'h36A0000000000000, 32'h00000001, 27};
        vecs[9]  = '{64'h3690000000000000, 32'h00000000, 28};
        vecs[10] = '{64'h380FFFFFF0000000, 32'h00800000, 5};

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", input_a_ack, 0);
        check("rst_stb", output_z_stb, 0);
        check("rst_z", output_z, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("ack_after_rst", input_a_ack, 1);

        for (int i = 0; i < 11; i++)
            conv($sformatf("vec%0d", i), vecs[i].a, vecs[i].z, vecs[i].lat);

        // output held under backpressure
        send(64'h3FF0000000000000);
        recv(z, lat);
        check("bp_first_z", z, 32'h3F800000);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_z", output_z, 32'h3F800000);
            check("bp_stb", output_z_stb, 1);
        end
        release_z();

        // idle input: ack stays up, nothing emitted
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("idle_ack", input_a_ack, 1);
            check("idle_stb", output_z_stb, 0);
        end

        // reset during the align loop
        send(64'h3690000000000000);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_ack", input_a_ack, 0);
        check("midrst_stb", output_z_stb, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            check("midrst_no_stale", output_z_stb, 0);
        end
        conv("after_midrst", 64'hBFB999999999999A, 32'hBDCCCCCD, 4);

        // reset while a result is waiting: strobe drops without a clock edge
        send(64'h3FF0000000000000);
        recv(z, lat);
        check("putz_stb_before", output_z_stb, 1);
        rst = 1'b0;
        #1;
        check("putz_rst_stb", output_z_stb, 0);
        check("putz_rst_z", output_z, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("putz_no_stale", output_z_stb, 0);
        end
        conv("after_putz_rst", 64'h36A0000000000000, 32'h00000001, 27);

        // random stream weighted toward the subnormal and overflow boundaries
        for (int i = 0; i < 20; i++) begin
            d = {$urandom, $urandom};
            sel = int'($urandom_range(0, 9));
            d[62:52] = sel < 6 ? 11'($urandom_range(865, 905)) :
                       sel < 8 ? 11'($urandom_range(0, 2047)) :
                       sel == 8 ? 11'd2047 : 11'($urandom_range(1140, 1160));
            if ($urandom_range(0, 3) == 0) d[26:0] = '0;
            conv($sformatf("rand_%h", d), d, model(d), lat_model(d));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
